fmap_writer: RTL and testbench
==============================

Name: fmap_writer

Overview:
- Write-side counterpart of the padded-window address generator.
- Takes convolution/activation result pixels as a row-major valid/ready stream and writes them into a feature-map BRAM with a row stride of IMG_W.
- Surrounds the interior with a zero border of pad_x columns and pad_y rows, so the next layer's reader can fetch directly from a padded frame.
- Sits between the conv datapath output and the next layer's input BRAM write port.

Parameters:
- IMG_W, 64: row stride of the target BRAM, in words.
- ADDR_W, 13: BRAM address width.
- DATA_W, 16: pixel width, two's complement.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that begins a frame
- out_w  in  7  interior (unpadded) width
- out_h  in  7  interior (unpadded) height
- pad_x  in  4  zero columns on each of the left and right sides
- pad_y  in  4  zero rows on each of the top and bottom sides
- in_pix  in  DATA_W  result pixel
- in_valid  in  1  in_pix is valid
- in_ready  out  1  writer accepts in_pix this cycle
- we  out  1  BRAM write enable
- waddr  out  ADDR_W  BRAM write address
- wdata  out  DATA_W  BRAM write data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst is synchronous, active-high.
  - Reset values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0. Internal counters are 0 and the FSM is in IDLE.
- Frame latch:
  - In IDLE, start=1 latches out_w, out_h, pad_x, pad_y and sets the scan position x=0, y=0.
  - Padded frame size: PW = out_w + 2*pad_x, PH = out_h + 2*pad_y, both computed 8 bits wide.
  - Start is ignored, and the FSM stays in IDLE, when any of these hold: out_w==0, out_h==0, PW>IMG_W, or PH*IMG_W > 2^ADDR_W.
- FSM states:
  - IDLE: busy=0. Go to SCAN on an accepted start.
  - SCAN: busy=1. Walks (x,y) row-major over PW x PH, one position per advance.
    - A position is border when x<pad_x, x>=pad_x+out_w, y<pad_y, or y>=pad_y+out_h.
    - Border position: in_ready=0. The writer advances unconditionally and issues a write of 0.
    - Interior position: in_ready=1. The writer advances only when in_valid=1 and issues a write of in_pix. With in_valid=0 it stalls at that position and issues no write.
    - After the write at (PW-1, PH-1), go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- in_ready:
  - Combinational from the FSM state and the current position only; it never depends on in_valid.
  - A transfer occurs when in_valid and in_ready are both 1 in the same cycle.
- Write port:
  - we, waddr and wdata are registered: each write appears one cycle after its advance.
  - waddr = y*IMG_W + x, truncated to ADDR_W bits.
  - we is low on every cycle without an advance.
  - Exactly PW*PH writes per frame, each address written once, in strictly increasing address order within a row.
- Throughput: one write per cycle when in_valid is held high. Total frame time is PW*PH cycles plus upstream stall cycles.
- Boundaries:
  - pad_x=0 and pad_y=0: there are no border writes, only interior writes.
  - Row wrap: when x reaches PW-1, x returns to 0 and y increments.
  - start while busy: ignored; the latched parameters do not change.
  - Parameter ports changing mid-frame: no effect on the frame in progress.
  - rst mid-frame: on the next edge all outputs return to their reset values and the FSM is in IDLE. The partial frame is abandoned and done does not pulse.
  - start asserted in the FIN cycle: ignored. A new frame may start on the following cycle at the earliest.

Optional Feature:
- Macro FMAP_WRITER_RELU_EN.
- Defined: interior pixels with in_pix[DATA_W-1]=1 are written as 0; non-negative pixels pass unchanged. Border zeros are unaffected. Latency and handshake are unchanged.
- Undefined: in_pix is written unmodified.

Test Plan:
- out_w=2, out_h=2, pad_x=1, pad_y=1, in_valid held 1 with pixels 1,2,3,4:
  - 16 writes to addresses 0-3, 64-67, 128-131, 192-195.
  - Data 4 at address 130; 0 at every border address.
  - done pulses 1 cycle after the last write, 17 cycles after start.
- Same configuration with in_valid low for 3 cycles before pixel 3:
  - in_ready stays 1 and we stays 0 during the stall.
  - Write order and addresses unchanged; done delayed by exactly 3 cycles.
- out_w=3, out_h=1, pad_x=0, pad_y=0:
  - 3 writes to addresses 0, 1, 2; in_ready is never 0 while busy.
- Reject cases:
  - out_w=63, pad_x=1 (PW=65): no busy, no writes, no done.
  - start pulsed while busy: the current frame is unaffected.
- rst asserted at write 5 of the first scenario:
  - Next cycle we=0, busy=0 and no done.
  - A fresh start then produces a full 16-write frame.
- FMAP_WRITER_RELU_EN defined, interior pixels -5 and 7:
  - Written values are 0 and 7.
  - Without the macro, the values are 16'hFFFB and 7.

Source files
------------

// File: rtl/fmap_writer_if.sv
// Result-pixel stream into fmap_writer and the feature-map BRAM write port out of it.
interface fmap_writer_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] in_pix;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (output in_pix, in_valid, input in_ready, we, waddr, wdata);
  modport slave  (input in_pix, in_valid, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/fmap_writer.sv
// Writes a row-major result stream into a feature-map BRAM framed by a zero border.
// Build option FMAP_WRITER_RELU_EN clamps negative interior pixels to zero on write.
module fmap_writer #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [6:0]   out_w,
  input  logic [6:0]   out_h,
  input  logic [3:0]   pad_x,
  input  logic [3:0]   pad_y,
  fmap_writer_if.slave bus,
  output logic         busy,
  output logic         done
);
  localparam int unsigned DIM_W     = 8;
  localparam int unsigned SPAN_W    = 32;
  localparam int unsigned ADDR_SPAN = 32'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
  state_t state;

  logic [DIM_W-1:0]  pw, ph, x_end, y_end, x, y;
  logic [3:0]        px, py;
  logic [ADDR_W-1:0] row_base;

  logic [DIM_W-1:0]  pw_c, ph_c;
  logic              start_ok_c, border_c, advance_c, row_end_c, last_c;
  logic [DATA_W-1:0] pix_c;

  // Padded frame size and acceptance check, evaluated on the live ports
  always_comb begin
    pw_c       = DIM_W'(out_w) + DIM_W'({pad_x, 1'b0});
    ph_c       = DIM_W'(out_h) + DIM_W'({pad_y, 1'b0});
    start_ok_c = start && (out_w != '0) && (out_h != '0)
              && (SPAN_W'(pw_c) <= IMG_W)
              && ((SPAN_W'(ph_c) * IMG_W) <= ADDR_SPAN);
  end

  // Classify the current scan position and decide whether it advances
  always_comb begin
    border_c  = (x < DIM_W'(px)) || (x >= x_end) || (y < DIM_W'(py)) || (y >= y_end);
    advance_c = (state == SCAN) && (border_c || bus.in_valid);
    row_end_c = (x == pw - DIM_W'(1));
    last_c    = row_end_c && (y == ph - DIM_W'(1));
`ifdef FMAP_WRITER_RELU_EN
    pix_c     = bus.in_pix[DATA_W-1] ? '0 : bus.in_pix;
`else
    pix_c     = bus.in_pix;
`endif
  end

  assign bus.in_ready = (state == SCAN) && !border_c;

  // Row base tracks y*IMG_W so the address is an add rather than a multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      pw        <= '0;
      ph        <= '0;
      x_end     <= '0;
      y_end     <= '0;
      px        <= '0;
      py        <= '0;
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
    end else begin
      bus.we <= advance_c;
      done   <= (state == FIN);
      if (advance_c) begin
        bus.waddr <= row_base + ADDR_W'(x);
        bus.wdata <= border_c ? '0 : pix_c;
      end
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            pw       <= pw_c;
            ph       <= ph_c;
            px       <= pad_x;
            py       <= pad_y;
            x_end    <= DIM_W'(pad_x) + DIM_W'(out_w);
            y_end    <= DIM_W'(pad_y) + DIM_W'(out_h);
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (advance_c) begin
            if (last_c) begin
              busy  <= 1'b0;
              state <= FIN;
            end else if (row_end_c) begin
              x        <= '0;
              y        <= y + DIM_W'(1);
              row_base <= row_base + ADDR_W'(IMG_W);
            end else begin
              x <= x + DIM_W'(1);
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_writer.sv
// Directed bench for fmap_writer: cycle table for the basic padded frame plus sequences for stalls, rejects, reset and ReLU.
`timescale 1ns/1ps
module tb_fmap_writer;
  localparam int unsigned IMG_W  = 64;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] out_w = '0;
  logic [6:0] out_h = '0;
  logic [3:0] pad_x = '0;
  logic [3:0] pad_y = '0;
  logic       busy, done;

  fmap_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fmap_writer #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_w(out_w), .out_h(out_h), .pad_x(pad_x), .pad_y(pad_y),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] pix;
    logic        rdy;
    logic        we;
    int          addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] pix_q[$];
  logic [28:0] wr_q[$];
  int          done_cyc;
  int          rdy_low_busy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic [15:0] p, input logic r,
                              input logic w, input int a, input logic [15:0] d,
                              input logic b, input logic dn);
    vec_t t;
    t.start = s; t.valid = v; t.pix = p; t.rdy = r; t.we = w;
    t.addr = a; t.data = d; t.busy = b; t.done = dn;
    return t;
  endfunction

  task automatic set_cfg(input int w, input int h, input int px, input int py);
    out_w = 7'(w); out_h = 7'(h); pad_x = 4'(px); pad_y = 4'(py);
  endtask

  task automatic fill_pix(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(16'(i + 1));
  endtask

  // Drives one frame; optionally stalls before interior pixel stall_at and re-pulses start mid-frame
  task automatic run_frame(input int stall_at, input int stall_len, input int mid_start, input int max_cyc);
    int   pi;
    int   left;
    logic rdy, stalled;
    pi = 0; left = stall_len;
    wr_q.delete(); done_cyc = -1; rdy_low_busy = 0;
    start = 1'b1; bus.in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      rdy = bus.in_ready; stalled = 1'b0;
      if (busy && !rdy) rdy_low_busy++;
      if (c == mid_start) begin
        start = 1'b1; out_w = 7'd5; pad_x = 4'd0; out_h = 7'd9;
      end else begin
        start = 1'b0;
      end
      if (rdy && pi == stall_at && left > 0) begin
        bus.in_valid = 1'b0; left--; stalled = 1'b1;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_pix = (pi < pix_q.size()) ? pix_q[pi] : 16'h5A5A;
      end
      if (bus.in_valid && rdy) pi++;
      step();
      if (stalled) begin
        chk("stall_we", 32'(bus.we), 32'd0);
        chk("stall_rdy", 32'(bus.in_ready), 32'd1);
      end
      if (bus.we) wr_q.push_back({bus.waddr, bus.wdata});
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    bus.in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int px, input int py,
                             input int exp_done);
    int pw, ph, k, i;
    logic brd;
    logic [15:0] ed;
    pw = w + 2 * px; ph = h + 2 * py; k = 0;
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(pw * ph));
    for (int yy = 0; yy < ph; yy++) begin
      for (int xx = 0; xx < pw; xx++) begin
        i   = yy * pw + xx;
        brd = (xx < px) || (xx >= px + w) || (yy < py) || (yy >= py + h);
        ed  = brd ? 16'h0 : pix_q[k];
        if (!brd) k++;
        if (i < wr_q.size()) begin
          chk($sformatf("%s_addr%0d", tag, i), 32'(wr_q[i][28:16]), 32'(yy * IMG_W + xx));
          chk($sformatf("%s_data%0d", tag, i), 32'(wr_q[i][15:0]), 32'(ed));
        end
      end
    end
  endtask

  task automatic run_reject(input string tag);
    int nb, nw, nd;
    nb = 0; nw = 0; nd = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy) nb++;
      if (bus.we) nw++;
      if (done) nd++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd0);
    chk({tag, "_writes"}, 32'(nw), 32'd0);
    chk({tag, "_done_pulses"}, 32'(nd), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nd;
    logic [15:0] e0;
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;

    // Reset values
    rst = 1'b1;
    step(); step();
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    step();

    // 2x2 interior, 1-pixel border, pixels 1..4; start in FIN ignored, next cycle accepted
    set_cfg(2, 2, 1, 1);
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,   0, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,   0, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,   1, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,   2, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,   3, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,  64, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0001, 1, 1,  65, 16'h1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0002, 1, 1,  66, 16'h2, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,  67, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 128, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0003, 1, 1, 129, 16'h3, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0004, 1, 1, 130, 16'h4, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 131, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 192, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 193, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 194, 16'h0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 195, 16'h0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,   0, 16'h0, 0, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,   0, 16'h0, 1, 0));
    foreach (tbl[i]) begin
      start = tbl[i].start; bus.in_valid = tbl[i].valid; bus.in_pix = tbl[i].pix;
      chk($sformatf("tbl%0d_rdy", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      step();
      chk($sformatf("tbl%0d_we", i), 32'(bus.we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_waddr", i), 32'(bus.waddr), 32'(tbl[i].addr));
        chk($sformatf("tbl%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].data));
      end
    end
    start = 1'b0; bus.in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();

    // Three-cycle upstream stall before pixel 3
    set_cfg(2, 2, 1, 1); fill_pix(4);
    run_frame(2, 3, -1, 60);
    check_frame("stall", 2, 2, 1, 1, 20);

    // start and parameter changes mid-frame have no effect
    set_cfg(2, 2, 1, 1); fill_pix(4);
    run_frame(-1, 0, 5, 60);
    check_frame("midstart", 2, 2, 1, 1, 17);
    step(); step();

    // No padding: interior-only writes, in_ready held while busy
    set_cfg(3, 1, 0, 0); fill_pix(3);
    run_frame(-1, 0, -1, 20);
    check_frame("nopad", 3, 1, 0, 0, 4);
    chk("nopad_rdy_low_busy", 32'(rdy_low_busy), 32'd0);
    step();

    // Rejected configurations
    set_cfg(63, 2, 1, 0);  run_reject("rej_pw65");
    set_cfg(0, 2, 1, 1);   run_reject("rej_w0");
    set_cfg(2, 0, 1, 1);   run_reject("rej_h0");
    set_cfg(1, 127, 0, 1); run_reject("rej_ph129");

    // Largest accepted frame extents
    set_cfg(62, 1, 1, 0); fill_pix(62);
    run_frame(-1, 0, -1, 100);
    check_frame("pw64", 62, 1, 1, 0, 65);
    step();
    set_cfg(1, 126, 0, 1); fill_pix(126);
    run_frame(-1, 0, -1, 200);
    check_frame("ph128", 1, 126, 0, 1, 129);
    step();

    // Reset at the fifth write abandons the frame
    set_cfg(2, 2, 1, 1);
    start = 1'b1; step(); start = 1'b0;
    bus.in_valid = 1'b1; bus.in_pix = 16'h0001;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      step();
      if (bus.we) n++;
    end
    chk("rstmid_reached_w5", 32'(n), 32'd5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstmid_we", 32'(bus.we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_waddr", 32'(bus.waddr), 32'd0);
    chk("rstmid_wdata", 32'(bus.wdata), 32'd0);
    chk("rstmid_rdy", 32'(bus.in_ready), 32'd0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy || bus.we) nd++;
    end
    chk("rstmid_quiet", 32'(nd), 32'd0);
    bus.in_valid = 1'b0;
    fill_pix(4);
    run_frame(-1, 0, -1, 60);
    check_frame("after_rst", 2, 2, 1, 1, 17);
    step();

    // Negative interior pixel with and without ReLU
    set_cfg(2, 1, 0, 0);
    pix_q.delete(); pix_q.push_back(16'hFFFB); pix_q.push_back(16'h0007);
    run_frame(-1, 0, -1, 20);
`ifdef FMAP_WRITER_RELU_EN
    e0 = 16'h0000;
`else
    e0 = 16'hFFFB;
`endif
    chk("relu_nwrites", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      chk("relu_addr0", 32'(wr_q[0][28:16]), 32'd0);
      chk("relu_data0", 32'(wr_q[0][15:0]), 32'(e0));
      chk("relu_addr1", 32'(wr_q[1][28:16]), 32'd1);
      chk("relu_data1", 32'(wr_q[1][15:0]), 32'h0007);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
